sa_operand_sequencer: RTL and testbench

- Sits directly upstream of the bit-level systolic array; owns the array's sys_in1/sys_in2/sys_in_valid/readout/usexor controls.
- Buffers two N x N bit matrices (A, B) loaded word-by-word over a valid/ready port.
- Streams both matrices into the array with the diagonal skew the array requires, flushes the array, then drives the readout sweep.
- Forwards the N result rows with a valid strobe.

---
 rtl/sa_operand_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sa_operand_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_operand_sequencer.sv
// Operand sequencer for the bit-level systolic array.
//
// Buffers two N x N bit matrices (A, B) loaded one row word at a time. On start it
// streams both matrices into the array with a diagonal skew, flushes the array with
// zeros, then sweeps readout and forwards the N result rows (row N-1 first).
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   ld_valid/ld_ready load handshake; ld_sel picks the bank (0 = A, 1 = B),
//                     ld_data is the next row word of that bank
//   start, op_xor     run request; op_xor selects XOR (1) or OR (0) combine
//   busy, done        busy in FEED/READ; done pulses once after the last result row
//   sys_in1, sys_in2  skewed operand columns/rows to the array
//   sys_in_valid      high while feeding the array
//   readout, usexor   array readout sweep and combine mode
//   sa_out            array result row input
//   res_valid/res_data forwarded result row (res_data is zero when not valid)
module sa_operand_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic         ld_sel,
    input  logic [N-1:0] ld_data,
    input  logic         start,
    input  logic         op_xor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sys_in1,
    output logic [N-1:0] sys_in2,
    output logic         sys_in_valid,
    output logic         readout,
    output logic         usexor,
    input  logic [N-1:0] sa_out,
    output logic         res_valid,
    output logic [N-1:0] res_data
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = $clog2(N + 1);
    localparam int unsigned CW = $clog2(3 * N);

    localparam logic [KW-1:0] BankFull = KW'(N);
    localparam logic [CW-1:0] FeedLast = CW'(3 * N - 2);
    localparam logic [CW-1:0] ReadLast = CW'(N);

    typedef enum logic [1:0] {StIdle, StFeed, StRead} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] a_cnt_q, b_cnt_q;
    logic [N-1:0]  a_bank_q [N];
    logic [N-1:0]  b_bank_q [N];
    logic [N-1:0]  sys_in1_q, sys_in1_d;
    logic [N-1:0]  sys_in2_q, sys_in2_d;
    logic          usexor_q;
    logic          done_q;
    logic          ld_fire;
    logic          start_fire;
    logic          read_last;
    int            skew_k;

    always_comb begin
        ld_fire    = ld_valid && ld_ready;
        start_fire = start && (state_q == StIdle) &&
                     (a_cnt_q == BankFull) && (b_cnt_q == BankFull);
        read_last  = (state_q == StRead) && (cnt_q == ReadLast);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt is t in FEED and r in READ
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_fire) begin
                    state_d = StFeed;
                    cnt_d   = '0;
                end
            end
            StFeed: begin
                if (cnt_q == FeedLast) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRead: begin
                if (cnt_q == ReadLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Skewed operands for the coming cycle: lane j carries word (t - j) of its bank.
    // Computed from the next-state count so the registered value lines up with t.
    always_comb begin
        sys_in1_d = '0;
        sys_in2_d = '0;
        skew_k    = 0;
        if (state_d == StFeed) begin
            for (int j = 0; j < int'(N); j++) begin
                skew_k = int'(cnt_d) - j;
                if (skew_k >= 0 && skew_k < int'(N)) begin
                    sys_in1_d[j] = a_bank_q[skew_k[IW-1:0]][j];
                    sys_in2_d[j] = b_bank_q[skew_k[IW-1:0]][j];
                end
            end
        end
    end

    // Output logic
    always_comb begin
        busy         = (state_q != StIdle);
        sys_in_valid = (state_q == StFeed);
        readout      = (state_q == StRead);
        res_valid    = (state_q == StRead) && (cnt_q != '0);
        res_data     = res_valid ? sa_out : '0;
        ld_ready     = (state_q == StIdle) &&
                       (ld_sel ? (b_cnt_q < BankFull) : (a_cnt_q < BankFull));
        done         = done_q;
        usexor       = usexor_q;
        sys_in1      = sys_in1_q;
        sys_in2      = sys_in2_q;
    end

    // Banks, counters and registered array controls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                a_bank_q[i] <= '0;
                b_bank_q[i] <= '0;
            end
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            usexor_q  <= 1'b0;
            done_q    <= 1'b0;
            sys_in1_q <= '0;
            sys_in2_q <= '0;
        end else begin
            if (ld_fire) begin
                if (ld_sel) begin
                    b_bank_q[b_cnt_q[IW-1:0]] <= ld_data;
                    b_cnt_q                   <= b_cnt_q + KW'(1);
                end else begin
                    a_bank_q[a_cnt_q[IW-1:0]] <= ld_data;
                    a_cnt_q                   <= a_cnt_q + KW'(1);
                end
            end
            if (start_fire) begin
                usexor_q <= op_xor;
            end
            // Every operation needs a full reload; contents are simply overwritten.
            if (read_last) begin
                a_cnt_q <= '0;
                b_cnt_q <= '0;
            end
            done_q    <= read_last;
            sys_in1_q <= sys_in1_d;
            sys_in2_q <= sys_in2_d;
        end
    end

endmodule

// File: tb/tb_sa_operand_sequencer.sv
module tb_sa_operand_sequencer;
    localparam int N     = 8;
    localparam int FEED  = 3 * N - 1;
    localparam int OPLEN = FEED + N + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ld_valid = 1'b0;
    logic         ld_sel = 1'b0;
    logic [N-1:0] ld_data = '0;
    logic         start = 1'b0;
    logic         op_xor = 1'b0;
    logic [N-1:0] sa_out = '0;
    logic         ld_ready, busy, done, sys_in_valid, readout, usexor, res_valid;
    logic [N-1:0] sys_in1, sys_in2, res_data;

    int n_checks = 0;
    int n_fail   = 0;

    sa_operand_sequencer #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_sel       (ld_sel),
        .ld_data      (ld_data),
        .start        (start),
        .op_xor       (op_xor),
        .busy         (busy),
        .done         (done),
        .sys_in1      (sys_in1),
        .sys_in2      (sys_in2),
        .sys_in_valid (sys_in_valid),
        .readout      (readout),
        .usexor       (usexor),
        .sa_out       (sa_out),
        .res_valid    (res_valid),
        .res_data     (res_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: banks, op timeline, matrix product ----------------
    logic [N-1:0] ma [N];
    logic [N-1:0] mb [N];
    logic [N-1:0] exp_row [N];
    int           ac, bc, c;  // c = 0 idle, 1..OPLEN inside an op, OPLEN+1 done cycle
    logic         m_xor;

    function automatic logic [N-1:0] calc_row(input int i, input logic x);
        logic [N-1:0] row;
        int ones;
        row = '0;
        for (int j = 0; j < N; j++) begin
            ones = 0;
            for (int k = 0; k < N; k++) ones += int'(ma[k][j] & mb[k][i]);
            row[j] = x ? ones[0] : (ones != 0);
        end
        return row;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ac    <= 0;
            bc    <= 0;
            c     <= 0;
            m_xor <= 1'b0;
        end else if (c >= 1 && c < OPLEN) begin
            c <= c + 1;
        end else if (c == OPLEN) begin
            c  <= OPLEN + 1;
            ac <= 0;
            bc <= 0;
        end else begin
            c <= 0;
            if (ld_valid && !ld_sel && ac < N) begin
                ma[ac] <= ld_data;
                ac     <= ac + 1;
            end
            if (ld_valid && ld_sel && bc < N) begin
                mb[bc] <= ld_data;
                bc     <= bc + 1;
            end
            if (start && ac == N && bc == N) begin
                c     <= 1;
                m_xor <= op_xor;
                for (int i = 0; i < N; i++) exp_row[i] <= calc_row(i, op_xor);
            end
        end
    end

    // ---------------- behavioural array: PE(i,j) meets in1[j] delayed i, in2[i] delayed j ----
    logic [N-1:0] h1 [FEED];
    logic [N-1:0] h2 [FEED];
    int           feed_n;
    int           rd_idx = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            feed_n <= 0;
        end else if (sys_in_valid) begin
            if (feed_n < FEED) begin
                h1[feed_n] <= sys_in1;
                h2[feed_n] <= sys_in2;
            end
            feed_n <= feed_n + 1;
        end else if (!readout) begin
            feed_n <= 0;
        end
    end

    function automatic logic [N-1:0] arr_row(input int i);
        logic [N-1:0] row;
        logic p;
        int lim, a, b;
        lim = (feed_n < FEED) ? feed_n : FEED;
        row = '0;
        for (int j = 0; j < N; j++) begin
            for (int s = 0; s < FEED + 2 * N; s++) begin
                a = s - i;
                b = s - j;
                if (a >= 0 && a < lim && b >= 0 && b < lim) begin
                    p = h1[a][j] & h2[b][i];
                    row[j] = usexor ? (row[j] ^ p) : (row[j] | p);
                end
            end
        end
        return row;
    endfunction

    // Array presents row N-r during readout cycle r (r >= 1); noise otherwise.
    always @(posedge clk) begin
        #1;
        if (readout) begin
            sa_out = (rd_idx >= 1 && rd_idx <= N) ? arr_row(N - rd_idx) : N'($urandom);
            rd_idx++;
        end else begin
            rd_idx = 0;
            sa_out = N'($urandom);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] got [$];

    always @(negedge clk) begin
        int t, r, k;
        bit idle, feeding, reading;
        logic [N-1:0] e1, e2, er;
        idle    = (c == 0 || c == OPLEN + 1);
        feeding = (c >= 1 && c <= FEED);
        reading = (c > FEED && c <= OPLEN);
        t = c - 1;
        r = c - FEED - 1;
        e1 = '0;
        e2 = '0;
        for (int j = 0; j < N; j++) begin
            k = t - j;
            if (feeding && k >= 0 && k < N) begin
                e1[j] = ma[k][j];
                e2[j] = mb[k][j];
            end
        end
        er = (reading && r >= 1) ? exp_row[N - r] : '0;
        chk("ld_ready", ld_ready, idle && (ld_sel ? (bc < N) : (ac < N)));
        chk("busy", busy, !idle);
        chk("done", done, c == OPLEN + 1);
        chk("sys_in_valid", sys_in_valid, feeding);
        chk("readout", readout, reading);
        chk("res_valid", res_valid, reading && r >= 1);
        chk("sys_in1", sys_in1, e1);
        chk("sys_in2", sys_in2, e2);
        chk("res_data", res_data, er);
        chk("usexor", usexor, m_xor);
        if (res_valid) got.push_back(res_data);
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] wa [N];
    logic [N-1:0] wb [N];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seq(input logic sel, input int count);
        for (int k = 0; k < count; k++) begin
            ld_valid = 1'b1;
            ld_sel   = sel;
            ld_data  = sel ? wb[k] : wa[k];
            cyc();
        end
        ld_valid = 1'b0;
    endtask

    task automatic load_random();
        int ia, ib;
        bit s;
        ia = 0;
        ib = 0;
        while (ia < N || ib < N) begin
            if (ia == N) s = 1'b1;
            else if (ib == N) s = 1'b0;
            else s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                ld_valid = 1'b0;
                cyc();
            end
            ld_valid = 1'b1;
            ld_sel   = s;
            ld_data  = s ? wb[ib] : wa[ia];
            cyc();
            if (s) ib++;
            else ia++;
        end
        ld_valid = 1'b0;
    endtask

    task automatic do_start(input logic x);
        start  = 1'b1;
        op_xor = x;
        cyc();
        start  = 1'b0;
        op_xor = 1'($urandom);
    endtask

    // Runs until done with noise on the inputs while busy.
    task automatic wait_op();
        bit found;
        found = 1'b0;
        for (int n = 0; n < OPLEN + 10 && !found; n++) begin
            if (busy) begin
                ld_valid = 1'($urandom);
                ld_sel   = 1'($urandom);
                ld_data  = N'($urandom);
                start    = 1'($urandom);
                op_xor   = 1'($urandom);
            end else begin
                ld_valid = 1'b0;
                start    = 1'b0;
            end
            @(negedge clk);
            if (done) found = 1'b1;
            cyc();
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        chk("op_completes", found, 1'b1);
    endtask

    task automatic check_rows(input string name, input logic [N-1:0] e [N]);
        chk({name, "_count"}, got.size(), N);
        for (int q = 0; q < N && q < got.size(); q++) chk(name, got[q], e[q]);
    endtask

    task automatic set_identity();
        for (int k = 0; k < N; k++) begin
            wa[k] = N'(1) << k;
            wb[k] = N'(1) << k;
        end
    endtask

    initial begin
        logic [N-1:0] e [N];
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] e [N];
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_ready", ld_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sys_in_valid", sys_in_valid, 1'b0);
        chk("rst_readout", readout, 1'b0);
        chk("rst_sys_in1", sys_in1, '0);
        reset = 1'b0;
        cyc();

        // Identity x identity, OR: rows emitted 0x80 down to 0x01
        set_identity();
        load_seq(1'b0, N);
        load_seq(1'b1, N);
        got.delete();
        do_start(1'b0);
        wait_op();
        for (int q = 0; q < N; q++) e[q] = 8'h80 >> q;
        check_rows("ident_rows", e);

        // A = identity, B = {0x3C, 0, ...}: rows 2..5 = 0x01
        for (int k = 0; k < N; k++) wb[k] = '0;
        wb[0] = 8'h3C;
        load_random();
        got.delete();
        do_start(1'b0);
        wait_op();
        for (int q = 0; q < N; q++) e[q] = (q >= 2 && q <= 5) ? 8'h01 : 8'h00;
        check_rows("transpose_rows", e);

        // All ones: XOR of 8 terms is 0, OR is all ones
        for (int k = 0; k < N; k++) begin
            wa[k] = '1;
            wb[k] = '1;
        end
        load_random();
        got.delete();
        do_start(1'b1);
        wait_op();
        for (int q = 0; q < N; q++) e[q] = 8'h00;
        check_rows("ones_xor_rows", e);
        load_random();
        got.delete();
        do_start(1'b0);
        wait_op();
        for (int q = 0; q < N; q++) e[q] = 8'hFF;
        check_rows("ones_or_rows", e);

        // Start with B one short is ignored; full bank refuses, other bank still loads
        for (int k = 0; k < N; k++) begin
            wa[k] = N'($urandom);
            wb[k] = N'($urandom);
        end
        load_seq(1'b0, N);
        load_seq(1'b1, N - 1);
        do_start(1'b0);
        chk("short_start_busy", busy, 1'b0);
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_data  = 8'hAA;
        #1;
        chk("full_a_ready", ld_ready, 1'b0);
        ld_sel = 1'b1;
        #1;
        chk("open_b_ready", ld_ready, 1'b1);
        ld_valid = 1'b0;
        cyc();
        ld_valid = 1'b1;
        ld_sel   = 1'b1;
        ld_data  = wb[N-1];
        cyc();
        ld_sel  = 1'b0;
        ld_data = 8'h55;
        #1;
        chk("ninth_a_ready", ld_ready, 1'b0);
        cyc();
        ld_valid = 1'b0;
        do_start(1'b1);
        chk("full_start_busy", busy, 1'b1);
        wait_op();

        // Reset in the middle of FEED, then a clean identity run
        set_identity();
        load_seq(1'b0, N);
        load_seq(1'b1, N);
        do_start(1'b1);
        repeat (5) cyc();
        chk("feed_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_sys_in_valid", sys_in_valid, 1'b0);
        chk("mid_rst_readout", readout, 1'b0);
        chk("mid_rst_ld_ready", ld_ready, 1'b1);
        chk("mid_rst_usexor", usexor, 1'b0);
        cyc();
        reset  = 1'b0;
        ld_sel = 1'b1;
        #1;
        chk("post_rst_b_ready", ld_ready, 1'b1);
        load_seq(1'b0, N);
        load_seq(1'b1, N);
        got.delete();
        do_start(1'b0);
        wait_op();
        for (int q = 0; q < N; q++) e[q] = 8'h80 >> q;
        check_rows("post_rst_rows", e);

        // Back-to-back random operations
        for (int op = 0; op < 6; op++) begin
            for (int k = 0; k < N; k++) begin
                wa[k] = N'($urandom);
                wb[k] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            end
            load_random();
            do_start(1'($urandom));
            wait_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
